// File: rtl/wta_disp_sched_pkg.sv
// Shared defaults, FSM state encoding and sizing helpers for the
// winner-take-all disparity scheduler.
package wta_disp_sched_pkg;

    localparam int DEF_NUM_DISP = 16;
    localparam int DEF_COST_W   = 5;
    localparam int LANES        = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A single group still needs a one-bit counter to keep the datapath legal.
    function automatic int grp_idx_width(input int num_disp);
        return (num_disp / LANES > 1) ? $clog2(num_disp / LANES) : 1;
    endfunction

endpackage

// File: rtl/wta_disp_sched_if.sv
// Cost-vector input and winning-disparity output handshakes of the scheduler.
interface wta_disp_sched_if
    import wta_disp_sched_pkg::*;
#(
    parameter int NUM_DISP = DEF_NUM_DISP,
    parameter int COST_W   = DEF_COST_W
);

    localparam int DISP_W = $clog2(NUM_DISP);

    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_DISP*COST_W-1:0] in_costs;
    logic                       out_valid;
    logic                       out_ready;
    logic [DISP_W-1:0]          out_disp;
    logic [COST_W-1:0]          out_cost;

    modport master (
        output in_valid, in_costs, out_ready,
        input  in_ready, out_valid, out_disp, out_cost
    );

    modport slave (
        input  in_valid, in_costs, out_ready,
        output in_ready, out_valid, out_disp, out_cost
    );

endinterface

// File: rtl/wta_min4.sv
// Shared 4-input minimum stage: registered minimum cost and its in-group
// index, lower index winning on equal costs.
module wta_min4
    import wta_disp_sched_pkg::*;
#(
    parameter int COST_W = DEF_COST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic [COST_W-1:0] c0,
    input  logic [COST_W-1:0] c1,
    input  logic [COST_W-1:0] c2,
    input  logic [COST_W-1:0] c3,
    output logic [COST_W-1:0] min_cost,
    output logic [1:0]        min_idx
);

    logic              lo_take1;
    logic              hi_take3;
    logic              take_hi;
    logic [COST_W-1:0] lo_cost;
    logic [COST_W-1:0] hi_cost;

    // Every comparison keeps the lower-indexed operand when costs are equal.
    always_comb begin
        lo_take1 = !(c0 <= c1);
        hi_take3 = !(c2 <= c3);
        lo_cost  = lo_take1 ? c1 : c0;
        hi_cost  = hi_take3 ? c3 : c2;
        take_hi  = !(lo_cost <= hi_cost);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_cost <= '0;
            min_idx  <= '0;
        end else if (clken) begin
            min_cost <= take_hi ? hi_cost : lo_cost;
            min_idx  <= take_hi ? {1'b1, hi_take3} : {1'b0, lo_take1};
        end
    end

endmodule

// File: rtl/wta_disp_sched.sv
// Winner-take-all disparity scheduler: streams a buffered cost vector four
// costs per cycle through wta_min4 and keeps a running minimum across groups.
module wta_disp_sched
    import wta_disp_sched_pkg::*;
#(
    parameter int NUM_DISP = DEF_NUM_DISP,
    parameter int COST_W   = DEF_COST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    wta_disp_sched_if.slave   bus,
    output logic              busy
);

    localparam int DISP_W   = $clog2(NUM_DISP);
    localparam int GROUPS   = NUM_DISP / LANES;
    localparam int GRP_W    = grp_idx_width(NUM_DISP);
    localparam int GRP_BITS = LANES * COST_W;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);

    state_t state;
    state_t state_nxt;

    logic [NUM_DISP*COST_W-1:0] vec_buf;
    logic [GRP_W-1:0]           grp_cnt;
    logic [GRP_W-1:0]           issue_grp;
    logic                       issue_vld;
    logic [GRP_BITS-1:0]        grp_costs;

    logic [COST_W-1:0]          loc_cost;
    logic [1:0]                 loc_idx;
    logic [COST_W-1:0]          acc_cost;
    logic [DISP_W-1:0]          acc_disp;
    logic [COST_W-1:0]          res_cost;
    logic [DISP_W-1:0]          res_disp;

    logic                       accept;
    logic                       issue;
    logic                       drain_done;

    // Handshake flags are pure decodes of the state register.
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_disp  = res_disp;
    assign bus.out_cost  = res_cost;
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else if (clken) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        issue      = 1'b0;
        drain_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                issue = 1'b1;
                if (grp_cnt == LAST_GRP) begin
                    state_nxt = ST_DRAIN;
                end
            end
            // The last group is still in the compare register until issue_vld drops.
            ST_DRAIN: begin
                if (!issue_vld) begin
                    drain_done = 1'b1;
                    state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vec_buf   <= '0;
            grp_cnt   <= '0;
            issue_vld <= 1'b0;
            issue_grp <= '0;
        end else if (clken) begin
            if (accept) begin
                vec_buf <= bus.in_costs;
                grp_cnt <= '0;
            end else if (issue) begin
                grp_cnt <= grp_cnt + 1'b1;
            end
            issue_vld <= issue;
            issue_grp <= grp_cnt;
        end
    end

    assign grp_costs = vec_buf[grp_cnt*GRP_BITS +: GRP_BITS];

    wta_min4 #(
        .COST_W (COST_W)
    ) u_min4 (
        .clk      (clk),
        .rst      (rst),
        .clken    (clken),
        .c0       (grp_costs[0*COST_W +: COST_W]),
        .c1       (grp_costs[1*COST_W +: COST_W]),
        .c2       (grp_costs[2*COST_W +: COST_W]),
        .c3       (grp_costs[3*COST_W +: COST_W]),
        .min_cost (loc_cost),
        .min_idx  (loc_idx)
    );

    // Strict less-than keeps the earliest group, hence the lowest disparity, on ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_cost <= '0;
            acc_disp <= '0;
        end else if (clken && issue_vld) begin
            if ((issue_grp == '0) || (loc_cost < acc_cost)) begin
                acc_cost <= loc_cost;
                acc_disp <= DISP_W'({issue_grp, loc_idx});
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_cost <= '0;
            res_disp <= '0;
        end else if (clken && drain_done) begin
            res_cost <= acc_cost;
            res_disp <= acc_disp;
        end
    end

endmodule

// File: tb/tb_wta_disp_sched.sv
// Self-checking bench for wta_disp_sched: directed corner vectors plus random
// vectors compared against a plain argmin reference model.
module tb_wta_disp_sched;

    localparam int NUM_DISP = 16;
    localparam int COST_W   = 5;
    localparam int G        = NUM_DISP / 4;
    localparam int VW       = NUM_DISP * COST_W;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic clken = 1'b1;
    logic busy;

    int total = 0;
    int bad   = 0;
    int last_d;
    int last_c;

    always #5 clk = ~clk;

    wta_disp_sched_if #(.NUM_DISP(NUM_DISP), .COST_W(COST_W)) bus ();

    wta_disp_sched #(
        .NUM_DISP (NUM_DISP),
        .COST_W   (COST_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clken (clken),
        .bus   (bus),
        .busy  (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: first index holding the smallest cost.
    function automatic void ref_wta(input logic [VW-1:0] v, output int d, output int c);
        c = 1 << COST_W;
        d = 0;
        for (int i = 0; i < NUM_DISP; i++) begin
            if (int'(v[i*COST_W +: COST_W]) < c) begin
                c = int'(v[i*COST_W +: COST_W]);
                d = i;
            end
        end
    endfunction

    function automatic logic [VW-1:0] fill_vec(input int val);
        logic [VW-1:0] v;
        for (int i = 0; i < NUM_DISP; i++) v[i*COST_W +: COST_W] = COST_W'(val);
        return v;
    endfunction

    function automatic logic [VW-1:0] set_cost(input logic [VW-1:0] v, input int idx, input int val);
        logic [VW-1:0] r;
        r = v;
        r[idx*COST_W +: COST_W] = COST_W'(val);
        return r;
    endfunction

    task automatic startVector(input logic [VW-1:0] v, input string tag);
        bus.in_valid = 1'b1;
        bus.in_costs = v;
        checkOutput({tag, "_in_ready_pre"}, bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput({tag, "_busy_post"}, busy, 1);
        checkOutput({tag, "_in_ready_post"}, bus.in_ready, 0);
    endtask

    task automatic waitResult(input logic [VW-1:0] v, input int off_start, input int off_len, input string tag);
        int edges    = 0;
        int en_edges = 0;
        bit seen     = 1'b0;
        while (!seen && edges < 60) begin
            clken = !(edges >= off_start && edges < off_start + off_len);
            @(posedge clk);
            edges++;
            if (clken) en_edges++;
            @(negedge clk);
            seen = bus.out_valid;
        end
        clken = 1'b1;
        ref_wta(v, last_d, last_c);
        checkOutput({tag, "_valid"}, seen, 1);
        checkOutput({tag, "_lat_en"}, en_edges, G + 2);
        checkOutput({tag, "_lat_all"}, edges, G + 2 + off_len);
        checkOutput({tag, "_disp"}, bus.out_disp, last_d);
        checkOutput({tag, "_cost"}, bus.out_cost, last_c);
        checkOutput({tag, "_in_ready_done"}, bus.in_ready, 0);
    endtask

    task automatic releaseResult(input int hold, input bit pre, input logic [VW-1:0] nv, input string tag);
        for (int i = 0; i < hold; i++) begin
            if (pre) begin
                bus.in_valid = 1'b1;
                bus.in_costs = nv;
            end
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, bus.out_valid, 1);
            checkOutput({tag, "_hold_in_ready"}, bus.in_ready, 0);
            checkOutput({tag, "_hold_disp"}, bus.out_disp, last_d);
            checkOutput({tag, "_hold_cost"}, bus.out_cost, last_c);
        end
        if (pre) begin
            bus.in_valid = 1'b1;
            bus.in_costs = nv;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, "_rel_valid"}, bus.out_valid, 0);
        checkOutput({tag, "_rel_in_ready"}, bus.in_ready, 1);
        if (pre) begin
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            checkOutput({tag, "_next_busy"}, busy, 1);
            checkOutput({tag, "_next_in_ready"}, bus.in_ready, 0);
        end
    endtask

    task automatic applyStimulus(input logic [VW-1:0] v, input int off_start, input int off_len,
                                 input int hold, input string tag);
        startVector(v, tag);
        waitResult(v, off_start, off_len, tag);
        releaseResult(hold, 1'b0, '0, tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [VW-1:0] v;
        logic [VW-1:0] w;

        bus.in_valid  = 1'b0;
        bus.in_costs  = '0;
        bus.out_ready = 1'b0;
        clken         = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_disp", bus.out_disp, 0);
        checkOutput("rst_out_cost", bus.out_cost, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", bus.in_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", bus.in_ready, 1);

        v = '0;
        for (int i = 0; i < NUM_DISP; i++) v = set_cost(v, i, i + 10);
        v = set_cost(v, 9, 3);
        applyStimulus(v, 0, 0, 0, "distinct");

        v = fill_vec(20);
        v = set_cost(v, 2, 0);
        v = set_cost(v, 13, 0);
        v = set_cost(v, 5, 4);
        v = set_cost(v, 6, 4);
        applyStimulus(v, 0, 0, 0, "tie_groups");
        v = set_cost(v, 2, 7);
        applyStimulus(v, 0, 0, 0, "tie_raise2");
        v = set_cost(v, 13, 7);
        applyStimulus(v, 0, 0, 0, "tie_in_group");

        applyStimulus(fill_vec(31), 0, 0, 0, "all_max");
        applyStimulus(set_cost(fill_vec(31), 15, 0), 0, 0, 0, "last_zero");

        v = fill_vec(12);
        v = set_cost(v, 7, 2);
        w = set_cost(fill_vec(9), 11, 1);
        startVector(v, "backpressure");
        waitResult(v, 0, 0, "backpressure");
        releaseResult(10, 1'b1, w, "backpressure");
        waitResult(w, 0, 0, "queued");
        releaseResult(0, 1'b0, '0, "queued");

        v = fill_vec(25);
        v = set_cost(v, 10, 6);
        applyStimulus(v, 1, 3, 0, "clken_stall");

        startVector(fill_vec(30), "abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_out_valid", bus.out_valid, 0);
        checkOutput("abort_in_ready", bus.in_ready, 1);
        checkOutput("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_rel_in_ready", bus.in_ready, 1);
        checkOutput("abort_rel_out_valid", bus.out_valid, 0);
        v = fill_vec(18);
        v = set_cost(v, 4, 1);
        applyStimulus(v, 0, 0, 0, "after_abort");

        for (int n = 0; n < 24; n++) begin
            int hi;
            hi = (n % 2 == 1) ? 31 : 3;
            for (int i = 0; i < NUM_DISP; i++) v = set_cost(v, i, int'($urandom_range(0, hi)));
            applyStimulus(v, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
